// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states,
// access sizes and small decode helpers.
package lsu_defs;

    typedef enum logic [2:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU,
        OP_LW, OP_SB, OP_SH, OP_SW
    } lsu_op_e;

    typedef enum logic [1:0] {
        S_IDLE, S_ACCESS, S_WRITE, S_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] op_size(lsu_op_e op);
        unique case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_is_load(lsu_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH)
            || (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_signed(lsu_op_e op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
        return ((size == SZ_W) && (off != 2'b00))
            || ((size == SZ_H) && off[0]);
    endfunction

    // Offset forced to natural alignment when misaligned accesses proceed.
    function automatic logic [1:0] align_off(logic [1:0] size, logic [1:0] off);
        unique case (size)
            SZ_W:    return 2'b00;
            SZ_H:    return {off[1], 1'b0};
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and memory-side bus of the load/store unit.
// The master side drives requests and returns memory read data.
interface lsu_if;
    import lsu_defs::*;

    logic        req;
    lsu_op_e     op;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        ready;
    logic        done;
    logic        error;
    logic [31:0] loadData;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;

    modport master (
        output req, op, address, storeData, memReadData,
        input  ready, done, error, loadData,
        input  memAddress, memWriteData, memRead, memWrite
    );

    modport slave (
        input  req, op, address, storeData, memReadData,
        output ready, done, error, loadData,
        output memAddress, memWriteData, memRead, memWrite
    );
endinterface

// File: rtl/load_store_unit_lane.sv
// Little-endian lane extract (with sign/zero extension) and lane merge
// for byte, halfword and word accesses.
module lsu_lane
    import lsu_defs::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] data_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        ext_o    = word_i;
        merged_o = word_i;
        unique case (1'b1)
            size_i == SZ_B: begin
                ext_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
                merged_o[{off_i, 3'b000} +: 8] = data_i[7:0];
            end
            size_i == SZ_H: begin
                ext_o = {{16{sign_i & half_sel[15]}}, half_sel};
                merged_o[{off_i[1], 4'b0000} +: 16] = data_i[15:0];
            end
            default: merged_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word-wide memory accesses with
// read-modify-write for sub-word stores and misalignment flagging.
module load_store_unit
    import lsu_defs::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] merge_q;
    logic [31:0] load_q;
    logic        err_q;

    logic [1:0]  size_in;
    logic        mis_in;
    logic [31:0] lane_word;
    logic [31:0] lane_ext;
    logic [31:0] lane_merged;
    logic        ready, done, error, rd, wr;
    logic [31:0] mem_addr, mem_wdata;

    assign size_in = op_size(bus.op);
    assign mis_in  = ALIGN_CHECK && misaligned(size_in, bus.address[1:0]);

    // WRITE merges into the captured word; ACCESS extracts from memory.
    assign lane_word = (state_q == S_WRITE) ? merge_q : bus.memReadData;

    lsu_lane u_lane (
        .word_i   (lane_word),
        .off_i    (addr_q[1:0]),
        .size_i   (op_size(op_q)),
        .sign_i   (op_signed(op_q)),
        .data_i   (sdata_q),
        .ext_o    (lane_ext),
        .merged_o (lane_merged)
    );

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.req) state_d = mis_in ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (op_q == OP_SW) begin
                    wr        = 1'b1;
                    mem_wdata = sdata_q;
                    state_d   = S_RESP;
                end else begin
                    rd      = 1'b1;
                    state_d = op_is_load(op_q) ? S_RESP : S_WRITE;
                end
            end
            S_WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                wr        = 1'b1;
                mem_wdata = lane_merged;
                state_d   = S_RESP;
            end
            S_RESP: begin
                done    = 1'b1;
                error   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LB;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            merge_q <= 32'h0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.req) begin
                op_q    <= bus.op;
                addr_q  <= {bus.address[31:2],
                            align_off(size_in, bus.address[1:0])};
                sdata_q <= bus.storeData;
                err_q   <= mis_in;
            end
            if (state_q == S_ACCESS) begin
                if (op_is_load(op_q)) load_q <= lane_ext;
                if (op_q == OP_SB || op_q == OP_SH) merge_q <= bus.memReadData;
            end
        end
    end

    // Reset must be able to cancel a write already on the bus.
    assign bus.memRead      = rd & rst_n;
    assign bus.memWrite     = wr & rst_n;
    assign bus.memAddress   = mem_addr;
    assign bus.memWriteData = mem_wdata;
    assign bus.ready        = ready;
    assign bus.done         = done;
    assign bus.error        = error;
    assign bus.loadData     = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random requests checked every
// cycle against a request-level reference model.
module tb_load_store_unit;
    import lsu_defs::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_if a ();
    lsu_if b ();

    load_store_unit #(.ALIGN_CHECK(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(a.slave));
    load_store_unit #(.ALIGN_CHECK(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b.slave));

    logic [31:0] mem [16];
    logic [31:0] mem1 [16];
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] seed_word(int i);
        if (i == 1) return 32'h11223344;
        if (i == 2) return 32'h80FF7F01;
        return (32'(i) * 32'h01010101) ^ 32'h5A5AA5A5;
    endfunction

    // Memories: combinational read, write on the rising edge.
    assign a.memReadData = a.memRead ? mem[a.memAddress[5:2]] : 32'h0;
    assign b.memReadData = b.memRead ? mem1[b.memAddress[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= seed_word(i);
                mem1[i] <= seed_word(i);
            end
        end else begin
            if (a.memWrite) mem[a.memAddress[5:2]] <= a.memWriteData;
            if (b.memWrite) mem1[b.memAddress[5:2]] <= b.memWriteData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: one request at a time, described by its size,
    // latency and architectural effect.
    function automatic int sz(lsu_op_e o);
        if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
        if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(lsu_op_e o);
        return o == OP_LB || o == OP_LBU || o == OP_LH
            || o == OP_LHU || o == OP_LW;
    endfunction

    function automatic bit is_mis(lsu_op_e o, logic [31:0] ad);
        return (int'(ad[1:0]) % sz(o)) != 0;
    endfunction

    function automatic logic [31:0] load_val(lsu_op_e o, logic [31:0] w,
                                             int off);
        logic [31:0] v;
        v = w >> (8 * off);
        if (sz(o) == 1) v = v & 32'hFF;
        if (sz(o) == 2) v = v & 32'hFFFF;
        if (o == OP_LB && v[7]) v = v | 32'hFFFFFF00;
        if (o == OP_LH && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [31:0] store_val(lsu_op_e o, logic [31:0] w,
                                              logic [31:0] d, int off);
        logic [63:0] m;
        logic [31:0] mk;
        m  = (64'd1 << (8 * sz(o))) - 64'd1;
        mk = m[31:0] << (8 * off);
        return (w & ~mk) | ((d & m[31:0]) << (8 * off));
    endfunction

    bit          busy = 1'b0;
    int          rem = 0;
    bit          exp_mis;
    int          exp_rd, exp_wr;
    bit          has_load, has_store;
    logic [31:0] pend_load, pend_store, exp_load;
    int          st_idx;

    always @(posedge clk) begin
        if (preload)
            for (int i = 0; i < 16; i++) ref_mem[i] <= seed_word(i);
        if (!rst_n) begin
            busy     <= 1'b0;
            rem      <= 0;
            exp_load <= 32'h0;
        end else if (!busy) begin
            if (a.req) begin
                busy      <= 1'b1;
                exp_mis   <= is_mis(a.op, a.address);
                rem       <= is_mis(a.op, a.address) ? 1 :
                             (a.op == OP_SB || a.op == OP_SH) ? 3 : 2;
                exp_rd    <= (is_mis(a.op, a.address) || a.op == OP_SW) ? 0 : 1;
                exp_wr    <= (is_mis(a.op, a.address) || is_ld(a.op)) ? 0 : 1;
                has_load  <= !is_mis(a.op, a.address) && is_ld(a.op);
                has_store <= !is_mis(a.op, a.address) && !is_ld(a.op);
                st_idx    <= int'(a.address[5:2]);
                pend_load <= load_val(a.op, ref_mem[a.address[5:2]],
                                      int'(a.address[1:0]));
                pend_store <= store_val(a.op, ref_mem[a.address[5:2]],
                                        a.storeData, int'(a.address[1:0]));
            end
        end else begin
            rem <= rem - 1;
            // The edge before the response is where data is committed.
            if (rem == 2 && has_load) exp_load <= pend_load;
            if (rem == 2 && has_store) ref_mem[st_idx] <= pend_store;
            if (rem == 1) busy <= 1'b0;
        end
    end

    function automatic bit mem_ok();
        for (int i = 0; i < 16; i++)
            if (mem[i] !== ref_mem[i]) return 1'b0;
        return 1'b1;
    endfunction

    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(a.ready), 32'(!busy));
            chk("done", 32'(a.done), 32'(busy && rem == 1));
            chk("loadData", a.loadData, exp_load);
            if (busy && rem == 1) begin
                chk("error", 32'(a.error), 32'(exp_mis));
                chk("read_cycles", rd_cnt, exp_rd);
                chk("write_cycles", wr_cnt, exp_wr);
                chk("memory", 32'(mem_ok()), 32'd1);
            end
            if (!busy || rem == 1) begin
                chk("idle_rw", {30'd0, a.memRead, a.memWrite}, 32'd0);
                chk("idle_addr", a.memAddress, 32'd0);
                chk("idle_wdata", a.memWriteData, 32'd0);
            end
            if (!busy) begin
                rd_cnt <= 0;
                wr_cnt <= 0;
            end else begin
                rd_cnt <= rd_cnt + int'(a.memRead);
                wr_cnt <= wr_cnt + int'(a.memWrite);
            end
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic issue(input lsu_op_e o, input logic [31:0] ad,
                         input logic [31:0] d, input bit wait_done,
                         input bit junk);
        bit acc = 1'b0;
        bit got = 1'b0;
        a.req = 1'b1;
        a.op = o;
        a.address = ad;
        a.storeData = d;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = a.ready;
            @(posedge clk);
            #1;
        end
        chk("accepted", 32'(acc), 32'd1);
        a.req = 1'b0;
        if (junk) begin
            a.req = 1'b1;
            a.op = OP_SW;
            a.address = 32'h0;
            a.storeData = 32'hFFFFFFFF;
            @(posedge clk);
            #1;
            a.req = 1'b0;
        end
        if (wait_done) begin
            for (int k = 0; k < 8 && !got; k++) begin
                got = a.done;
                if (!got) begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("done_seen", 32'(got), 32'd1);
        end
    endtask

    task automatic issue_b(input lsu_op_e o, input logic [31:0] ad,
                           output int lat);
        bit acc = 1'b0;
        lat = -1;
        b.req = 1'b1;
        b.op = o;
        b.address = ad;
        b.storeData = 32'h0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = b.ready;
            @(posedge clk);
            #1;
        end
        b.req = 1'b0;
        for (int k = 1; k < 8 && lat < 0; k++) begin
            if (b.done) lat = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w_before;
        int lat;
        a.req = 1'b0; a.op = OP_LB; a.address = 0; a.storeData = 0;
        b.req = 1'b0; b.op = OP_LB; b.address = 0; b.storeData = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        preload = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 32'(a.ready), 32'd1);
        chk("rst_done", 32'(a.done), 32'd0);
        chk("rst_loadData", a.loadData, 32'd0);

        issue(OP_LB, 32'hA, 0, 1, 0);
        chk("lb_a", a.loadData, 32'hFFFFFFFF);
        issue(OP_LBU, 32'hB, 0, 1, 0);
        chk("lbu_b", a.loadData, 32'h00000080);
        issue(OP_LH, 32'h8, 0, 1, 0);
        chk("lh_8", a.loadData, 32'h00007F01);
        issue(OP_LH, 32'hA, 0, 1, 0);
        chk("lh_a", a.loadData, 32'hFFFF80FF);
        issue(OP_LHU, 32'hA, 0, 1, 0);
        chk("lhu_a", a.loadData, 32'h000080FF);

        issue(OP_SB, 32'h5, 32'h123456AA, 1, 0);
        issue(OP_LW, 32'h4, 0, 1, 0);
        chk("sb_lw", a.loadData, 32'h1122AA44);
        issue(OP_SH, 32'h6, 32'h7777BEEF, 1, 0);
        issue(OP_LW, 32'h4, 0, 1, 0);
        chk("sh_lw", a.loadData, 32'hBEEFAA44);

        issue(OP_LW, 32'h6, 0, 1, 0);
        chk("mis_lw_err", 32'(a.error), 32'd1);
        chk("mis_lw_keep", a.loadData, 32'hBEEFAA44);
        issue(OP_SH, 32'h3, 32'hFFFF, 1, 0);
        chk("mis_sh_err", 32'(a.error), 32'd1);
        chk("mis_sh_mem", mem[0], seed_word(0));

        issue(OP_LB, 32'h8, 0, 1, 1);
        chk("junk_ignored", a.loadData, 32'h00000001);
        issue(OP_LBU, 32'h9, 0, 0, 0);
        issue(OP_LHU, 32'h8, 0, 1, 0);
        chk("held_req", a.loadData, 32'h00007F01);

        repeat (200)
            issue(lsu_op_e'($urandom_range(0, 7)), $urandom_range(0, 63),
                  $urandom, 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 10 && !a.ready; k++) begin
            @(posedge clk);
            #1;
        end

        w_before = ref_mem[4];
        issue(OP_SB, 32'h11, ~w_before, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstw_ready", 32'(a.ready), 32'd1);
        chk("rstw_done", 32'(a.done), 32'd0);
        chk("rstw_loadData", a.loadData, 32'd0);
        chk("rstw_mem", mem[4], w_before);

        issue_b(OP_LW, 32'h6, lat);
        chk("noalign_lw6", b.loadData, 32'h11223344);
        chk("noalign_lat", lat, 2);
        chk("noalign_err", 32'(b.error), 32'd0);
        issue_b(OP_LH, 32'hB, lat);
        chk("noalign_lh_b", b.loadData, 32'hFFFF80FF);
        issue_b(OP_LW, 32'h9, lat);
        chk("noalign_lw9", b.loadData, 32'h80FF7F01);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the MEM-stage pipeline control and the word-addressed data memory. It turns byte, halfword and word loads/stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word-wide memory reads and writes. Sub-word stores use read-modify-write. Loads are sign- or zero-extended. Misaligned requests are flagged. `ready` stalls the pipeline while an access is in flight.

## Interface
Parameters
- `ALIGN_CHECK`, default 1.
  - 1: misaligned requests raise `error` and make no memory access.
  - 0: offending low address bits are truncated to natural alignment and the access proceeds.

Ports (clock and reset first)
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 1: request strobe; sampled only while `ready`=1.
- `op` in 3: operation code from the shared package (LB, LBU, LH, LHU, LW, SB, SH, SW).
- `address` in 32: byte address.
- `storeData` in 32: store source; the low 8/16/32 bits are used.
- `ready` out 1: unit idle; a request is accepted this cycle.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`; marks a misaligned request.
- `loadData` out 32: extended load result; holds its value until the next load completes.
- `memAddress` out 32: word-aligned address to memory, `{addr[31:2],2'b00}`.
- `memWriteData` out 32: word to memory.
- `memRead` out 1: read enable to memory.
- `memWrite` out 1: write enable; memory commits on the rising edge.
- `memReadData` in 32: memory read word, combinational from `memAddress` and `memRead`.

## Operation
- Byte lanes are little-endian.
  - Byte at `addr[1:0]`=k is bits [8k+7:8k].
  - Halfword at `addr[1]`=h is bits [16h+15:16h].
- Alignment:
  - LW/SW require `addr[1:0]`=0.
  - LH/LHU/SH require `addr[0]`=0.
  - Byte ops are always aligned.
- States:
  - IDLE: `ready`=1. On `req`, latch `op`, `address` and `storeData`. Go to RESP if misaligned and `ALIGN_CHECK`=1; otherwise go to ACCESS.
  - ACCESS:
    - Loads: `memRead`=1; capture the extracted, extended lane into `loadData`; go to RESP.
    - SW: `memWrite`=1, `memWriteData`=storeData; go to RESP.
    - SB/SH: `memRead`=1; capture `memReadData` into the merge register; go to WRITE.
  - WRITE: `memWrite`=1; `memWriteData` is the merge register with the addressed lane replaced by the low bits of storeData; go to RESP.
  - RESP: `done`=1; `error` is set if the request was misaligned; go to IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- A misaligned load leaves `loadData` unchanged.
- Memory-side outputs are combinational from state and latched registers. In IDLE and RESP, `memAddress`, `memWriteData`, `memRead` and `memWrite` are all 0.
- `req` while `ready`=0 is ignored. It is not queued.

## Timing
- Request accepted at edge 0 (IDLE, `req`=1).
- `done` asserts in cycle:
  - cycle 2 for loads and SW;
  - cycle 3 for SB/SH;
  - cycle 1 for misaligned requests.
- `ready` returns to 1 in the cycle after `done`, so back-to-back throughput is one request per 3 (word/load) or 4 (sub-word store) cycles.
- `loadData` updates at the edge ending ACCESS and is stable while `done`=1.
- Reset (`rst_n`=0 sampled at an edge):
  - state goes to IDLE;
  - `loadData`, the latched registers and the merge register go to 0;
  - `done`=0, `error`=0, `ready`=1 after the edge.
- `memRead` and `memWrite` are gated by `rst_n`. A reset during WRITE or SW ACCESS commits nothing, and the in-flight operation is abandoned without `done`.

## Structure
- Shared package `lsu_defs`: `op` encodings, state encodings, and the lane-select helper constants.
- One combinational sub-module, `lsu_lane`:
  - extract: word, offset, size, sign → extended value;
  - merge: word, offset, size, data → merged word.
- The FSM, latches and alignment check stay in `load_store_unit`.

## Test plan
- Memory word 0x8 = 0x80FF7F01. LB at 0xA → `loadData`=0xFFFFFFFF. LBU at 0xB → 0x00000080. Each `done` in cycle 2.
- Same word. LH at 0x8 → 0x00007F01. LH at 0xA → 0xFFFF80FF. LHU at 0xA → 0x000080FF.
- Word 0x4 = 0x11223344. SB 0xAA at 0x5 then LW 0x4 → 0x1122AA44. SH 0xBEEF at 0x6 then LW → 0xBEEFAA44. Store `done` in cycle 3, exactly one `memWrite` cycle each.
- `ALIGN_CHECK`=1. LW at 0x6 and SH at 0x3 → `done` and `error` in cycle 1, `memRead`/`memWrite` never asserted, memory and `loadData` unchanged. With `ALIGN_CHECK`=0, LW at 0x6 returns the word at 0x4.
- `req` pulsed during ACCESS is ignored. A second request held until `ready` is accepted and completes normally.
- SB issued and `rst_n` driven low during WRITE → target word unchanged, no `done`. The next cycle shows `ready`=1 and `loadData`=0.
